// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier built from one 4x4 partial-product unit.
`timescale 1ns/1ps
package mult_seq_pkg;

   localparam int NIB_W  = 4;
   localparam int PP_W   = 8;
   localparam int RES_W  = 16;

   localparam int SH_LL  = 0;
   localparam int SH_MID = 4;
   localparam int SH_HH  = 8;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      S_LL = 3'd1,
      S_LH = 3'd2,
      S_HL = 3'd3,
      S_HH = 3'd4,
      DONE = 3'd5
   } state_t;

   // Keep-mask for a partial product whose 'bits' LSBs are dropped.
   function automatic logic [PP_W-1:0] hh_mask(input int unsigned bits);
      logic [PP_W-1:0] m;
      m = {PP_W{1'b1}} << bits;
      return m;
   endfunction

endpackage

// File: rtl/mul4x4_pp.sv
// Exact 4x4 partial-product unit; aligns the product for the active quadrant.
// Build option APPROX_HH_EN zeroes the low HH_TRUNC_BITS of the high x high product.
`timescale 1ns/1ps
module mul4x4_pp
   import mult_seq_pkg::*;
#(
   parameter int HH_TRUNC_BITS = 3
) (
   input  state_t           quad,
   input  logic [NIB_W-1:0] a_nib,
   input  logic [NIB_W-1:0] b_nib,
   output logic [RES_W-1:0] term
);

`ifdef APPROX_HH_EN
   localparam bit APPROX = 1'b1;
`else
   localparam bit APPROX = 1'b0;
`endif

   localparam logic [PP_W-1:0] HH_MASK = APPROX ? hh_mask(HH_TRUNC_BITS) : {PP_W{1'b1}};

   logic [PP_W-1:0] pp;

   assign pp = PP_W'(a_nib) * PP_W'(b_nib);

   // Outside the four compute states the unit contributes nothing.
   always_comb begin
      term = '0;
      case (quad)
         S_LL:       term = RES_W'(pp) << SH_LL;
         S_LH, S_HL: term = RES_W'(pp) << SH_MID;
         S_HH:       term = RES_W'(pp & HH_MASK) << SH_HH;
         default:    term = '0;
      endcase
   end

endmodule

// File: rtl/mult_8x8_seq_ctrl.sv
// Unsigned 8x8 multiplier sequencing one 4x4 unit over four cycles, valid/ready on both sides.
// Build option APPROX_HH_EN selects the truncated high x high quadrant (see mul4x4_pp).
`timescale 1ns/1ps
module mult_8x8_seq_ctrl
   import mult_seq_pkg::*;
#(
   parameter int HH_TRUNC_BITS = 3,
   parameter bit SKIP_ZERO     = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_a,
   input  logic [7:0]       in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [RES_W-1:0] out_r,
   output logic             busy
);

   state_t           state;
   state_t           state_nxt;
   logic [7:0]       a_q;
   logic [7:0]       b_q;
   logic [RES_W-1:0] acc;
   logic [NIB_W-1:0] a_nib;
   logic [NIB_W-1:0] b_nib;
   logic [RES_W-1:0] term;
   logic             accept;
   logic             zero_op;

   assign accept  = in_valid && (state == IDLE);
   assign zero_op = (in_a == 8'd0) || (in_b == 8'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (SKIP_ZERO && zero_op) state_nxt = DONE;
               else                      state_nxt = S_LL;
            end
         end
         S_LL:    state_nxt = S_LH;
         S_LH:    state_nxt = S_HL;
         S_HL:    state_nxt = S_HH;
         S_HH:    state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operands are captured on accept so the producer is free afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q <= '0;
         b_q <= '0;
         acc <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  a_q <= in_a;
                  b_q <= in_b;
                  acc <= '0;
               end
            end
            S_LL, S_LH, S_HL, S_HH: acc <= acc + term;
            default: ;
         endcase
      end
   end

   always_comb begin
      a_nib = a_q[3:0];
      b_nib = b_q[3:0];
      case (state)
         S_LH: b_nib = b_q[7:4];
         S_HL: a_nib = a_q[7:4];
         S_HH: begin
            a_nib = a_q[7:4];
            b_nib = b_q[7:4];
         end
         default: ;
      endcase
   end

   mul4x4_pp #(
      .HH_TRUNC_BITS(HH_TRUNC_BITS)
   ) u_pp (
      .quad  (state),
      .a_nib (a_nib),
      .b_nib (b_nib),
      .term  (term)
   );

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign out_r     = acc;

endmodule

// File: tb/tb_mult_8x8_seq_ctrl.sv
// Directed and randomised checks of mult_8x8_seq_ctrl against a reference product model.
`timescale 1ns/1ps
module tb_mult_8x8_seq_ctrl;

   localparam int TB_TRUNC = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_a = '0;
   logic [7:0]  in_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_r;
   logic        busy;

   logic        ns_in_valid = 1'b0;
   logic        ns_in_ready;
   logic [7:0]  ns_in_a = '0;
   logic [7:0]  ns_in_b = '0;
   logic        ns_out_valid;
   logic        ns_out_ready = 1'b0;
   logic [15:0] ns_out_r;
   logic        ns_busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mult_8x8_seq_ctrl #(.HH_TRUNC_BITS(TB_TRUNC), .SKIP_ZERO(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .busy(busy)
   );

   mult_8x8_seq_ctrl #(.HH_TRUNC_BITS(TB_TRUNC), .SKIP_ZERO(1'b0)) dut_ns (
      .clk(clk), .rst_n(rst_n),
      .in_valid(ns_in_valid), .in_ready(ns_in_ready), .in_a(ns_in_a), .in_b(ns_in_b),
      .out_valid(ns_out_valid), .out_ready(ns_out_ready), .out_r(ns_out_r), .busy(ns_busy)
   );

   // Exact product, minus the high-quadrant bits that the approximate build drops.
   function automatic logic [15:0] refProduct(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      logic [7:0]  hh;
      logic [7:0]  low;
      p   = 16'(a) * 16'(b);
      hh  = 8'(a[7:4]) * 8'(b[7:4]);
      low = (8'd1 << TB_TRUNC) - 8'd1;
`ifdef APPROX_HH_EN
      p = p - (16'(hh & low) << 8);
`else
      low = hh & 8'd0;
      p = p + 16'(low);
`endif
      return p;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Accept one operand pair, then measure edges until out_valid and check the result.
   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                input logic [15:0] exp_r, input int exp_lat, input string tag);
      int lat;
      int j;
      @(negedge clk);
      in_a = a;
      in_b = b;
      in_valid = 1'b1;
      checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_a = 8'($urandom);
      in_b = 8'($urandom);
      lat = 0;
      j = 1;
      while (lat == 0 && j <= 20) begin
         @(negedge clk);
         if (out_valid) lat = j;
         else begin
            @(posedge clk);
            j++;
         end
      end
      checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      checkOutput({tag, "_out_r"}, 32'(out_r), 32'(exp_r));
   endtask

   task automatic consumeResult(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
      checkOutput({tag, "_idle_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lat;
      int j;
      int sent;
      int recv;
      int cycles;
      logic fire_in;
      logic fire_out;
      logic [15:0] sb[$];

      // Reset values
      #12;
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_r", 32'(out_r), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

`ifdef APPROX_HH_EN
      applyStimulus(8'hFF, 8'hFF, 16'hFD01, 5, "ffxff");
`else
      applyStimulus(8'hFF, 8'hFF, 16'hFE01, 5, "ffxff");
`endif
      consumeResult("ffxff");

      applyStimulus(8'h00, 8'h77, 16'h0000, 1, "skip0");
      consumeResult("skip0");
      applyStimulus(8'h5A, 8'h00, 16'h0000, 1, "skip1");
      consumeResult("skip1");

      // Same zero operand on the instance that never skips
      @(negedge clk);
      ns_in_a = 8'h00;
      ns_in_b = 8'h77;
      ns_in_valid = 1'b1;
      @(posedge clk);
      #1;
      ns_in_valid = 1'b0;
      lat = 0;
      j = 1;
      while (lat == 0 && j <= 20) begin
         @(negedge clk);
         if (ns_out_valid) lat = j;
         else begin
            @(posedge clk);
            j++;
         end
      end
      checkOutput("noskip_latency", 32'(lat), 32'd5);
      checkOutput("noskip_out_r", 32'(ns_out_r), 32'd0);
      ns_out_ready = 1'b1;
      @(posedge clk);
      #1;
      ns_out_ready = 1'b0;
      checkOutput("noskip_idle", 32'(ns_in_ready), 32'd1);

      // Back-pressure on 0x12*0x34
`ifdef APPROX_HH_EN
      applyStimulus(8'h12, 8'h34, 16'h00A8, 5, "bp");
`else
      applyStimulus(8'h12, 8'h34, 16'h03A8, 5, "bp");
`endif
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         @(negedge clk);
`ifdef APPROX_HH_EN
         checkOutput("bp_hold_r", 32'(out_r), 32'h00A8);
`else
         checkOutput("bp_hold_r", 32'(out_r), 32'h03A8);
`endif
         checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
         checkOutput("bp_hold_in_ready", 32'(in_ready), 32'd0);
         checkOutput("bp_hold_busy", 32'(busy), 32'd1);
      end
      consumeResult("bp");

      // Reset while in S_HL
      @(negedge clk);
      in_a = 8'hAB;
      in_b = 8'hCD;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
      applyStimulus(8'h03, 8'h05, 16'h000F, 5, "after_abort");
      consumeResult("after_abort");

      // Randomised stream with gaps on both sides, results checked in order
      sent = 0;
      recv = 0;
      cycles = 0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      while (recv < 1000 && cycles < 40000) begin
         @(negedge clk);
         cycles++;
         fire_in  = in_valid && in_ready;
         fire_out = out_valid && out_ready;
         if (fire_out) begin
            if (sb.size() == 0) checkOutput("rand_unexpected", 32'd1, 32'd0);
            else checkOutput("rand_out_r", 32'(out_r), 32'(sb.pop_front()));
            recv++;
         end
         if (fire_in) begin
            sb.push_back(refProduct(in_a, in_b));
            sent++;
         end
         @(posedge clk);
         #1;
         if (fire_in || !in_valid) begin
            if (sent < 1000 && $urandom_range(0, 3) != 0) begin
               in_valid = 1'b1;
               in_a = 8'($urandom);
               in_b = 8'($urandom);
            end else begin
               in_valid = 1'b0;
            end
         end
         out_ready = ($urandom_range(0, 2) != 0);
      end
      checkOutput("rand_count", 32'(recv), 32'd1000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
